// File: rtl/mux_sel_pkg.sv
// rtl/mux_sel_pkg.sv - shared constants and helpers for the pipelined N:1 selector
package mux_sel_pkg;

    // Width of the saturating out-of-range transaction counter.
    localparam int OOR_CNT_W = 16;

    // Bit mask of legal tree fan-ins: bit r set means radix r is supported.
    localparam logic [4:0] RADIX_LEGAL_MASK = 5'b10100;

    // Number of radix-r stages needed to reduce n candidates to one (minimum 1).
    function automatic int clog_radix(input int n, input int r);
        int    l;
        longint p;
        l = 0;
        p = 1;
        for (int i = 0; i < 16; i++) begin
            if (p < longint'(n)) begin
                p = p * longint'(r);
                l = l + 1;
            end
        end
        return (l < 1) ? 1 : l;
    endfunction

    function automatic bit radix_legal(input int r);
        return (r >= 0) && (r < 5) && RADIX_LEGAL_MASK[r];
    endfunction

    // Select bits consumed per stage.
    function automatic int digit_w(input int r);
        return (r == 4) ? 2 : 1;
    endfunction

endpackage

// File: rtl/mux_sel_stage.sv
// rtl/mux_sel_stage.sv - one RADIX:1 select bank with its pipeline register
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   en                   advance enable; when low the register holds
//   in_valid/in_oor      transaction valid and out-of-range flag from the previous stage
//   in_cand              M_OUT groups of RADIX candidate words
//   in_sel               remaining select bits, low digit used here
//   out_valid/out_oor    registered valid and out-of-range flag
//   out_cand             M_OUT surviving words (registered)
//   out_sel              select bits left for later stages (registered)
module mux_sel_stage
    import mux_sel_pkg::*;
#(
    parameter int W     = 1,
    parameter int M_OUT = 1,
    parameter int RADIX = 4,
    parameter int SEL_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [M_OUT*RADIX*W-1:0] in_cand,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_oor,
    output logic                     out_valid,
    output logic [M_OUT*W-1:0]       out_cand,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_oor
);

    localparam int DW = digit_w(RADIX);

    logic [DW-1:0]        digit;
    logic [M_OUT*W-1:0]   pick;

    assign digit = in_sel[DW-1:0];

    always_comb begin
        pick = '0;
        for (int g = 0; g < M_OUT; g++) begin
            pick[g*W +: W] = in_cand[(g*RADIX + int'(digit))*W +: W];
        end
    end

    // A bubble only clears the valid bit; payload is left as-is to avoid toggling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_cand  <= '0;
            out_sel   <= '0;
            out_oor   <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_cand <= pick;
                out_sel  <= in_sel >> DW;
                out_oor  <= in_oor;
            end
        end
    end

endmodule

// File: rtl/mux_sel_pipe.sv
// rtl/mux_sel_pipe.sv - pipelined N:1 radix-tree selector with handshake and out-of-range tracking
//
// Build option: MUX_SEL_PIPE_OOR_CLAMP_EN
//   defined   - out-of-range selects forward word N-1, padding leaves replicate word N-1
//   undefined - out-of-range selects forward zero, padding leaves are zero
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_ready is combinational
//   in_data               N packed words, word i at [i*W +: W]
//   in_sel                index of the word to forward
//   out_valid/out_ready   output handshake
//   out_data, out_oor     selected word and its out-of-range flag (registered)
//   oor_sticky, oor_count statistics of accepted out-of-range transactions
//   oor_clr               synchronous clear of the statistics, wins over an increment
module mux_sel_pipe
    import mux_sel_pkg::*;
#(
    parameter int N     = 26,
    parameter int W     = 1,
    parameter int SEL_W = 8,
    parameter int RADIX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*W-1:0]       in_data,
    input  logic [SEL_W-1:0]     in_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic                 out_oor,
    output logic                 oor_sticky,
    output logic [OOR_CNT_W-1:0] oor_count,
    input  logic                 oor_clr
);

    localparam int L      = clog_radix(N, RADIX);
    localparam int LEAVES = RADIX ** L;

    localparam logic [SEL_W:0]   N_EXT    = (SEL_W+1)'(N);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N - 1);

    if (!radix_legal(RADIX) || (N < 2) || (N > 256) || ((2 ** SEL_W) < N)) begin : g_bad_cfg
        $fatal(1, "mux_sel_pipe: illegal configuration N=%0d SEL_W=%0d RADIX=%0d", N, SEL_W, RADIX);
    end

    logic                  en;
    logic                  accept;
    logic                  oor_in;
    logic [SEL_W-1:0]      sel0;
    logic [W-1:0]          pad_word;
    logic [LEAVES*W-1:0]   leaves_raw;
    logic [LEAVES*W-1:0]   leaves;
    logic [OOR_CNT_W-1:0]  cnt_q;
    logic                  sticky_q;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;
    assign accept   = in_valid & en;
    assign oor_in   = ({1'b0, in_sel} >= N_EXT);

`ifdef MUX_SEL_PIPE_OOR_CLAMP_EN
    assign pad_word = in_data[(N-1)*W +: W];
    // Steering an out-of-range select onto word N-1 also covers selects beyond the tree.
    assign sel0     = oor_in ? LAST_SEL : in_sel;
    assign leaves   = leaves_raw;
`else
    assign pad_word = '0;
    // Zeroing every leaf makes the result zero whatever path the select takes.
    assign sel0     = oor_in ? '0 : in_sel;
    assign leaves   = oor_in ? '0 : leaves_raw;
`endif

    if (LEAVES > N) begin : g_pad
        assign leaves_raw = {{(LEAVES-N){pad_word}}, in_data};
    end else begin : g_nopad
        assign leaves_raw = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else if (oor_clr) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else if (accept && oor_in) begin
            sticky_q <= 1'b1;
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign oor_sticky = sticky_q;
    assign oor_count  = cnt_q;

    for (genvar k = 0; k < L; k++) begin : g_st
        localparam int MO = RADIX ** (L - k - 1);

        logic [MO*RADIX*W-1:0] cin;
        logic [SEL_W-1:0]      sin;
        logic                  vin;
        logic                  oin;
        logic [MO*W-1:0]       cout;
        logic [SEL_W-1:0]      sout;
        logic                  vout;
        logic                  oout;

        if (k == 0) begin : g_head
            assign cin = leaves;
            assign sin = sel0;
            assign vin = in_valid;
            assign oin = oor_in;
        end else begin : g_link
            assign cin = g_st[k-1].cout;
            assign sin = g_st[k-1].sout;
            assign vin = g_st[k-1].vout;
            assign oin = g_st[k-1].oout;
        end

        mux_sel_stage #(
            .W     (W),
            .M_OUT (MO),
            .RADIX (RADIX),
            .SEL_W (SEL_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_valid  (vin),
            .in_cand   (cin),
            .in_sel    (sin),
            .in_oor    (oin),
            .out_valid (vout),
            .out_cand  (cout),
            .out_sel   (sout),
            .out_oor   (oout)
        );
    end

    assign out_valid = g_st[L-1].vout;
    assign out_data  = g_st[L-1].cout;
    assign out_oor   = g_st[L-1].oout;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// tb/tb_mux_sel_pipe.sv - randomized and directed self-checking bench for mux_sel_pipe
module tb_mux_sel_pipe;

`ifdef MUX_SEL_PIPE_OOR_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif
    localparam int LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic         a_vld, a_irdy, a_ordy, a_ov, a_oor, a_sticky, a_clr;
    logic [25:0]  a_data;
    logic [7:0]   a_sel;
    logic [0:0]   a_od;
    logic [15:0]  a_cnt;

    logic         b_vld, b_irdy, b_ordy, b_ov, b_oor, b_sticky, b_clr;
    logic [159:0] b_data;
    logic [7:0]   b_sel;
    logic [31:0]  b_od;
    logic [15:0]  b_cnt;

    mux_sel_pipe #(.N(26), .W(1), .SEL_W(8), .RADIX(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_vld), .in_ready(a_irdy), .in_data(a_data),
        .in_sel(a_sel), .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od), .out_oor(a_oor),
        .oor_sticky(a_sticky), .oor_count(a_cnt), .oor_clr(a_clr)
    );

    mux_sel_pipe #(.N(5), .W(32), .SEL_W(8), .RADIX(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_vld), .in_ready(b_irdy), .in_data(b_data),
        .in_sel(b_sel), .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od), .out_oor(b_oor),
        .oor_sticky(b_sticky), .oor_count(b_cnt), .oor_clr(b_clr)
    );

    typedef struct {
        logic [31:0] d;
        logic        oor;
        int          stamp;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   lat_on;
    int   m_cnt;
    bit   m_sticky;
    logic [31:0] held;

    function automatic logic [31:0] ref_a(input logic [25:0] d, input int s);
        if (s < 26) return 32'(d[s]);
        return CLAMP ? 32'(d[25]) : 32'd0;
    endfunction

    function automatic logic [31:0] ref_b(input logic [159:0] d, input int s);
        if (s < 5) return d[s*32 +: 32];
        return CLAMP ? d[4*32 +: 32] : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, record accepts, advance to the next negedge.
    task automatic tick();
        exp_t e;
        int   s;
        #1;
        chk("a_sticky", 64'(a_sticky), 64'(m_sticky));
        chk("a_count", 64'(a_cnt), 64'(m_cnt));
        if (rst_n && a_ov && a_ordy) begin
            if (qa.size() == 0) begin
                chk("a_spurious", 64'(a_ov), 64'd0);
            end else begin
                e = qa.pop_front();
                chk("a_data", 64'(a_od), 64'(e.d));
                chk("a_oor", 64'(a_oor), 64'(e.oor));
                if (lat_on) chk("a_latency", 64'(cyc - e.stamp), 64'(LAT));
            end
        end
        if (rst_n && b_ov && b_ordy) begin
            if (qb.size() == 0) begin
                chk("b_spurious", 64'(b_ov), 64'd0);
            end else begin
                e = qb.pop_front();
                chk("b_data", 64'(b_od), 64'(e.d));
                chk("b_oor", 64'(b_oor), 64'(e.oor));
                if (lat_on) chk("b_latency", 64'(cyc - e.stamp), 64'(LAT));
            end
        end
        if (rst_n) begin
            s = int'(a_sel);
            if (a_vld && a_irdy) qa.push_back('{ref_a(a_data, s), s >= 26, cyc});
            if (a_clr) begin
                m_cnt    = 0;
                m_sticky = 1'b0;
            end else if (a_vld && a_irdy && s >= 26) begin
                m_sticky = 1'b1;
                if (m_cnt < 65535) m_cnt++;
            end
            s = int'(b_sel);
            if (b_vld && b_irdy) qb.push_back('{ref_b(b_data, s), s >= 5, cyc});
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drv_a(input bit v, input int s, input logic [25:0] d);
        a_vld  = v;
        a_sel  = 8'(s);
        a_data = d;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        a_vld = 0; a_ordy = 1; a_clr = 0; a_sel = 0; a_data = 0;
        b_vld = 0; b_ordy = 1; b_clr = 0; b_sel = 0; b_data = 0;
        m_cnt = 0; m_sticky = 0; lat_on = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(a_ov), 64'd0);
        chk("rst_out_data", 64'(a_od), 64'd0);
        chk("rst_out_oor", 64'(a_oor), 64'd0);
        chk("rst_sticky", 64'(a_sticky), 64'd0);
        chk("rst_count", 64'(a_cnt), 64'd0);
        chk("rst_in_ready", 64'(a_irdy), 64'd1);
        chk("rst_b_out_valid", 64'(b_ov), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back sweep of every legal select.
        lat_on = 1;
        for (int s = 0; s < 26; s++) drv_a(1, s, 26'h2AAAAAA);
        repeat (5) drv_a(0, 0, 26'h0);

        // Out-of-range select with only word 25 set.
        drv_a(1, 30, 26'h2000000);
        repeat (5) drv_a(0, 0, 26'h0);
        chk("oor_sticky_1", 64'(a_sticky), 64'd1);
        chk("oor_count_1", 64'(a_cnt), 64'd1);

        // Three transactions in flight, output stalled for five cycles.
        lat_on = 0;
        a_ordy = 0;
        drv_a(1, 1, 26'h0000002);
        drv_a(1, 2, 26'h0000000);
        drv_a(1, 3, 26'h0000008);
        a_vld = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            held = qa[0].d;
            chk("stall_out_valid", 64'(a_ov), 64'd1);
            chk("stall_in_ready", 64'(a_irdy), 64'd0);
            chk("stall_hold", 64'(a_od), 64'(held));
            drv_a(1, 5, 26'h3FFFFFF);
        end
        a_ordy = 1;
        repeat (6) drv_a(0, 0, 26'h0);
        chk("stall_drained", 64'(qa.size()), 64'd0);

        // Stream through the N=5, W=32, RADIX=2 instance, in-range and out-of-range.
        lat_on = 1;
        for (int s = 0; s < 8; s++) begin
            b_vld  = 1;
            b_sel  = 8'(s);
            b_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
            tick();
        end
        b_vld = 0;
        repeat (5) tick();

        // Randomized traffic with back-pressure and occasional clears.
        lat_on = 0;
        for (int i = 0; i < 300; i++) begin
            a_vld  = ($urandom_range(0, 3) != 0);
            a_sel  = 8'($urandom_range(0, 31));
            a_data = 26'($urandom);
            a_ordy = ($urandom_range(0, 3) != 0);
            a_clr  = ($urandom_range(0, 15) == 0);
            b_vld  = ($urandom_range(0, 3) != 0);
            b_sel  = 8'($urandom_range(0, 7));
            b_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
            b_ordy = ($urandom_range(0, 3) != 0);
            tick();
        end
        a_vld = 0; a_clr = 0; a_ordy = 1; b_vld = 0; b_ordy = 1;
        repeat (6) tick();
        chk("rand_a_drained", 64'(qa.size()), 64'd0);
        chk("rand_b_drained", 64'(qb.size()), 64'd0);

        // Clear colliding with an out-of-range accept, starting from a count of 7.
        a_clr = 1;
        drv_a(0, 0, 26'h0);
        a_clr = 0;
        for (int i = 0; i < 7; i++) drv_a(1, 26 + i, 26'($urandom));
        a_vld = 0;
        #1;
        chk("pre_clr_count", 64'(a_cnt), 64'd7);
        a_clr = 1;
        drv_a(1, 40, 26'($urandom));
        a_clr = 0;
        drv_a(0, 0, 26'h0);
        #1;
        chk("clr_count", 64'(a_cnt), 64'd0);
        chk("clr_sticky", 64'(a_sticky), 64'd0);
        repeat (4) drv_a(0, 0, 26'h0);

        // Saturation from 16'hFFFE.
        dut_a.cnt_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        for (int i = 0; i < 3; i++) drv_a(1, 200 + i, 26'($urandom));
        repeat (4) drv_a(0, 0, 26'h0);
        chk("sat_count", 64'(a_cnt), 64'hFFFF);
        chk("sat_sticky", 64'(a_sticky), 64'd1);

        // Asynchronous reset with two transactions in flight.
        drv_a(1, 4, 26'h0000010);
        drv_a(1, 6, 26'h0000040);
        drv_a(0, 0, 26'h0);
        #2;
        chk("pre_rst_out_valid", 64'(a_ov), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(a_ov), 64'd0);
        chk("async_rst_in_ready", 64'(a_irdy), 64'd1);
        chk("async_rst_count", 64'(a_cnt), 64'd0);
        qa.delete();
        qb.delete();
        m_cnt = 0;
        m_sticky = 0;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(a_irdy), 64'd1);
        repeat (6) drv_a(0, 0, 26'h0);
        chk("post_rst_out_valid", 64'(a_ov), 64'd0);

        // Fresh stream after reset on both instances.
        lat_on = 1;
        for (int s = 0; s < 6; s++) begin
            b_vld  = 1;
            b_sel  = 8'(s);
            b_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
            drv_a(1, 20 + s, 26'($urandom));
        end
        b_vld = 0;
        repeat (5) drv_a(0, 0, 26'h0);
        chk("final_a_drained", 64'(qa.size()), 64'd0);
        chk("final_b_drained", 64'(qb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
